// File: rtl/d_ff_pipe.sv
// d_ff_pipe: elastic WIDTH x DEPTH valid/ready register pipeline (CLK,RST,FLUSH,D,in_valid->in_ready; Q,Qbar,out_valid<-out_ready; count)
module d_ff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         FLUSH,
  input  logic [WIDTH-1:0]             D,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             Q,
  output logic [WIDTH-1:0]             Qbar,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d, src_v;
  logic rdy [DEPTH+1];
  logic [CW-1:0] count_q, count_d;
  logic in_xfer, out_xfer;
  assign rdy[DEPTH] = out_ready;
  for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
    assign rdy[i] = !vld_q[i] | rdy[i+1];
  end
  assign in_ready  = RST | (rdy[0] & !FLUSH);
  assign in_xfer   = in_valid & rdy[0] & !FLUSH;
  assign out_xfer  = vld_q[DEPTH-1] & out_ready;
  assign Q         = data_q[DEPTH-1];
  assign Qbar      = ~data_q[DEPTH-1];
  assign out_valid = vld_q[DEPTH-1];
  assign count     = count_q;
  assign count_d   = count_q + CW'(in_xfer) - CW'(out_xfer);
  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = D;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = vld_q[k-1];
      src_d[k] = data_q[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      vld_d[k]  = rdy[k] ? src_v[k] : vld_q[k];
      data_d[k] = (rdy[k] & src_v[k]) ? src_d[k] : data_q[k];
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q   <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else if (FLUSH) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_d_ff_pipe.sv
// tb_d_ff_pipe: directed self-checking bench for d_ff_pipe at DEPTH=4 and DEPTH=1
module tb_d_ff_pipe;
  logic clk = 0, rst = 0, flush = 0;
  logic [7:0] d = 0, q, qb;
  logic iv = 0, ir, ov, ordy = 0;
  logic [2:0] cnt;
  logic [7:0] d1 = 0, q1, qb1;
  logic iv1 = 0, ir1, ov1, or1 = 0;
  logic [0:0] c1;
  int n_checks = 0, n_err = 0;
  always #5 clk = ~clk;
  d_ff_pipe #(.WIDTH(8), .DEPTH(4)) u4 (
    .CLK(clk), .RST(rst), .FLUSH(flush), .D(d), .in_valid(iv), .in_ready(ir),
    .Q(q), .Qbar(qb), .out_valid(ov), .out_ready(ordy), .count(cnt)
  );
  d_ff_pipe #(.WIDTH(8), .DEPTH(1)) u1 (
    .CLK(clk), .RST(rst), .FLUSH(flush), .D(d1), .in_valid(iv1), .in_ready(ir1),
    .Q(q1), .Qbar(qb1), .out_valid(ov1), .out_ready(or1), .count(c1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; iv = 1; d = 8'hA5; iv1 = 1; d1 = 8'hA5;
    #1 check("rst_in_ready", 32'(ir), 1);
    tick(); tick();
    rst = 0; iv = 0; iv1 = 0; ordy = 1; or1 = 1;
    #1;
    check("rst_q", 32'(q), 0);
    check("rst_qbar", 32'(qb), 32'hFF);
    check("rst_ov", 32'(ov), 0);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_q1", 32'(q1), 0);
    check("rst_ov1", 32'(ov1), 0);
    for (int j = 0; j < 5; j++) begin
      tick();
      check("rst_no_word", 32'(ov), 0);
    end
    for (int k = 1; k <= 8; k++) begin
      d = 8'(k); iv = 1;
      #1 check("stream_in_ready", 32'(ir), 1);
      tick();
      if (k >= 4) begin
        check("stream_q", 32'(q), 32'(k - 3));
        check("stream_ov", 32'(ov), 1);
        check("stream_cnt", 32'(cnt), 4);
      end else begin
        check("stream_fill_ov", 32'(ov), 0);
        check("stream_fill_cnt", 32'(cnt), 32'(k));
      end
    end
    iv = 0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      check("drain_cnt", 32'(cnt), 32'(4 - j));
      if (j < 4) check("drain_q", 32'(q), 32'(5 + j));
      else check("drain_empty", 32'(ov), 0);
    end
    ordy = 0;
    for (int w = 1; w <= 4; w++) begin
      d = 8'(w); iv = 1;
      #1 check("bp_in_ready", 32'(ir), 1);
      tick();
      iv = 0;
      check("bp_cnt", 32'(cnt), 32'(w));
      tick();
    end
    d = 8'h05; iv = 1;
    #1 check("bp_full_ready", 32'(ir), 0);
    check("bp_full_cnt", 32'(cnt), 4);
    iv = 0; ordy = 1;
    for (int j = 1; j <= 4; j++) begin
      #1 check("bp_rel_q", 32'(q), 32'(j));
      check("bp_rel_ov", 32'(ov), 1);
      tick();
    end
    check("bp_rel_empty", 32'(ov), 0);
    ordy = 0;
    for (int k = 0; k < 4; k++) begin
      d = 8'h21 + 8'(k); iv = 1;
      tick();
    end
    iv = 0;
    #1 check("full_cnt", 32'(cnt), 4);
    ordy = 1;
    for (int k = 0; k < 4; k++) begin
      d = 8'h25 + 8'(k); iv = 1;
      #1 check("full_in_ready", 32'(ir), 1);
      check("full_q", 32'(q), 32'h21 + 32'(k));
      tick();
      check("full_cnt_hold", 32'(cnt), 4);
    end
    iv = 0;
    for (int k = 0; k < 4; k++) begin
      check("full_drain_q", 32'(q), 32'h25 + 32'(k));
      tick();
    end
    check("full_drain_empty", 32'(ov), 0);
    ordy = 0;
    for (int k = 0; k < 3; k++) begin
      d = 8'h31 + 8'(k); iv = 1;
      tick();
    end
    iv = 0;
    tick();
    check("fl_pre_cnt", 32'(cnt), 3);
    check("fl_pre_q", 32'(q), 32'h31);
    flush = 1; iv = 1; d = 8'h3F; ordy = 1;
    #1 check("fl_in_ready", 32'(ir), 0);
    check("fl_ov_taken", 32'(ov), 1);
    tick();
    flush = 0; iv = 0;
    check("fl_ov", 32'(ov), 0);
    check("fl_cnt", 32'(cnt), 0);
    for (int j = 0; j < 5; j++) begin
      tick();
      check("fl_no_drop_word", 32'(ov), 0);
    end
    ordy = 0;
    d = 8'h41; iv = 1; tick();
    d = 8'h42; tick();
    rst = 1; flush = 1; d = 8'h4F; ordy = 1;
    #1 check("rp_in_ready", 32'(ir), 1);
    tick();
    rst = 0; flush = 0; iv = 0;
    check("rp_q", 32'(q), 0);
    check("rp_qbar", 32'(qb), 32'hFF);
    check("rp_ov", 32'(ov), 0);
    check("rp_cnt", 32'(cnt), 0);
    for (int j = 0; j < 4; j++) begin
      tick();
      check("rp_no_word", 32'(ov), 0);
    end
    or1 = 0; d1 = 8'h51; iv1 = 1;
    #1 check("d1_empty_ready", 32'(ir1), 1);
    tick();
    check("d1_q", 32'(q1), 32'h51);
    check("d1_ov", 32'(ov1), 1);
    check("d1_cnt", 32'(c1), 1);
    d1 = 8'h52;
    #1 check("d1_stall_ready", 32'(ir1), 0);
    tick();
    check("d1_stall_q", 32'(q1), 32'h51);
    check("d1_stall_qbar", 32'(qb1), 32'hAE);
    or1 = 1;
    #1 check("d1_rel_ready", 32'(ir1), 1);
    tick();
    check("d1_rel_q", 32'(q1), 32'h52);
    check("d1_rel_ov", 32'(ov1), 1);
    iv1 = 0;
    tick();
    check("d1_drain_ov", 32'(ov1), 0);
    check("d1_drain_cnt", 32'(c1), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
